irq_encoder: RTL

Registered priority encoder and interrupt handshake block: the inverse of the 5-to-32 active-low line decoder. It samples 32 active-low request lines (bit n low = line n asserted; line 0 is reserved and never asserted, matching the decoder's all-ones output for index 0). It latches them into a pending register and offers the lowest-numbered enabled pending line as a 5-bit code over a valid/ack handshake. Sits between peripheral request lines and the CP0 exception logic; code 0 means "no request".

---
 rtl/irq_encoder_pkg.sv | 18 +
 rtl/irq_encoder_if.sv | 14 +
 rtl/irq_encoder_prio_enc32.sv | 23 ++
 rtl/irq_encoder.sv | 80 ++++++++
 4 files changed

// File: rtl/irq_encoder_pkg.sv
// Shared constants and types for the interrupt priority encoder.
package irq_pkg;
    localparam int IRQ_LINES  = 32;
    localparam int IRQ_CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        CLR   = 2'd2
    } irq_state_e;

    localparam logic [IRQ_CODE_W-1:0] NO_IRQ = '0;

    // One-hot line vector selecting the line named by a code.
    function automatic logic [IRQ_LINES-1:0] code_onehot(input logic [IRQ_CODE_W-1:0] c);
        return IRQ_LINES'(1) << c;
    endfunction
endpackage

// File: rtl/irq_encoder_if.sv
// Request/offer/acknowledge bundle between peripherals, the encoder and CP0.
interface irq_encoder_if;
    import irq_pkg::*;

    logic [IRQ_LINES-1:0]  req_n;
    logic [IRQ_LINES-1:0]  mask;
    logic [IRQ_CODE_W-1:0] code;
    logic                  valid;
    logic                  ack;
    logic [IRQ_LINES-1:0]  pending;

    modport slave  (input  req_n, mask, ack, output code, valid, pending);
    modport master (output req_n, mask, ack, input  code, valid, pending);
endinterface

// File: rtl/irq_encoder_prio_enc32.sv
// Combinational lowest-index-wins encoder over lines 1..31; line 0 never wins.
module prio_enc32
    import irq_pkg::*;
(
    input  logic [IRQ_LINES-1:0]  i_cand,
    output logic [IRQ_CODE_W-1:0] o_idx,
    output logic                  o_any
);
    logic [IRQ_LINES-1:0] w_cand;

    assign w_cand = i_cand & ~IRQ_LINES'(1);
    assign o_any  = |w_cand;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        o_idx = NO_IRQ;
        for (int i = IRQ_LINES - 1; i >= 1; i--) begin
            if (w_cand[i]) begin
                o_idx = IRQ_CODE_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_encoder.sv
// Pending-request register plus IDLE/OFFER/CLR handshake that offers the
// lowest-numbered enabled pending line to the exception logic.
module irq_encoder
    import irq_pkg::*;
#(
    parameter bit STICKY = 1'b1
)(
    input  logic          clk,
    input  logic          rst_n,
    irq_encoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_OFFER = OFFER;
    localparam logic [1:0] S_CLR   = CLR;

    logic [1:0]            r_state;
    logic [IRQ_CODE_W-1:0] r_code;
    logic [IRQ_LINES-1:0]  r_pending;

    logic [IRQ_LINES-1:0]  w_req;
    logic [IRQ_LINES-1:0]  w_cand;
    logic [IRQ_LINES-1:0]  w_clr;
    logic [IRQ_LINES-1:0]  w_pending_next;
    logic [IRQ_CODE_W-1:0] w_win;
    logic                  w_any;
    logic                  w_take;

    assign w_req  = ~bus.req_n & ~IRQ_LINES'(1);
    assign w_cand = r_pending & bus.mask;
    assign w_take = (r_state == S_OFFER) && bus.ack;
    assign w_clr  = w_take ? code_onehot(r_code) : '0;

    // OR-ing the request in after the clear makes a same-edge set win.
    assign w_pending_next = (STICKY ? (r_pending & ~w_clr) : '0) | w_req;

    prio_enc32 u_prio (
        .i_cand (w_cand),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // The code is captured on entry to OFFER and held until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= NO_IRQ;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_OFFER;
                        r_code  <= w_win;
                    end
                end
                S_OFFER: begin
                    if (bus.ack) begin
                        r_state <= S_CLR;
                        r_code  <= NO_IRQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_code  <= NO_IRQ;
                end
            endcase
        end
    end

    assign bus.code    = r_code;
    assign bus.valid   = (r_state == S_OFFER);
    assign bus.pending = r_pending;
endmodule
